// File: rtl/nmea_pkg.sv
// rtl/nmea_pkg.sv - shared types and constants for the NMEA replay controller
// Purpose: FSM state encoding, ASCII framing constants, the "GPRMC," header
//          bytes and a saturating 8-bit increment helper.
// Ports:   none (package)
package nmea_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_COLLECT,
    ST_CK_HI,
    ST_CK_LO,
    ST_CHECK,
    ST_REPLAY,
    ST_WAIT_DONE,
    ST_ABORT
  } state_t;

  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] COMMA  = 8'h2C;

  // "GPRMC," sentence header, first six payload bytes
  localparam logic [7:0] HDR_G = 8'h47;
  localparam logic [7:0] HDR_P = 8'h50;
  localparam logic [7:0] HDR_R = 8'h52;
  localparam logic [7:0] HDR_M = 8'h4D;
  localparam logic [7:0] HDR_C = 8'h43;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nmea_hex2nib.sv
// rtl/nmea_hex2nib.sv - ASCII hex digit to nibble decoder
// Purpose: maps '0'-'9', 'A'-'F', 'a'-'f' to a 4-bit value; flags anything else.
// Ports:   i_char   in  8  ASCII byte
//          o_nib    out 4  decoded value (0 when not hex)
//          o_is_hex out 1  i_char is a hex digit
module nmea_hex2nib (
  input  logic [7:0] i_char,
  output logic [3:0] o_nib,
  output logic       o_is_hex
);

  always_comb begin
    o_nib    = 4'd0;
    o_is_hex = 1'b0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_nib    = i_char[3:0];
      o_is_hex = 1'b1;
    end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                 (i_char >= 8'h61 && i_char <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so +9 lands on 10
      o_nib    = i_char[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/nmea_replay_ctrl.sv
// rtl/nmea_replay_ctrl.sv - NMEA sentence capture, checksum and paced replay
// Purpose: captures one sentence from the UART, verifies its XOR checksum and
//          replays checksum-valid GPRMC sentences to the time parser with GAP
//          idle cycles between bytes; supervises parser completion.
// Ports:   clk, rst (async, active-low)
//          rx_data/rx_valid     in   received UART byte strobe
//          p_char/p_valid       out  paced byte stream to the parser
//          p_done               in   parser completion
//          p_rst_n              out  one-cycle parser reset on timeout
//          busy                 out  controller not in HUNT
//          ok_cnt/err_cnt       out  saturating sentence counters
//          fix_lost             out  no p_done for FIX_LOSS_CYC cycles
module nmea_replay_ctrl
  import nmea_pkg::*;
#(
  parameter int BUF_DEPTH    = 128,
  parameter int GAP          = 2,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int FIX_LOSS_CYC = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] p_char,
  output logic       p_valid,
  input  logic       p_done,
  output logic       p_rst_n,
  output logic       busy,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt,
  output logic       fix_lost
);

  localparam int IW = $clog2(BUF_DEPTH);
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int FW = $clog2(FIX_LOSS_CYC + 1);

  state_t        r_state;
  logic [7:0]    r_buf [BUF_DEPTH];
  logic [IW:0]   r_idx;
  logic [IW:0]   r_rp;
  logic [7:0]    r_xor;
  logic [7:0]    r_ck;
  logic [GW-1:0] r_gap;
  logic [TW-1:0] r_tmo;
  logic [FW-1:0] r_fl_cnt;
  logic [7:0]    r_p_char;
  logic          r_p_valid;
  logic          r_p_rst_n;
  logic [7:0]    r_ok_cnt;
  logic [7:0]    r_err_cnt;
  logic          r_fix_lost;

  logic [3:0]    w_nib;
  logic          w_is_hex;
  logic          w_buf_we;
  logic          w_hdr_ok;
  logic [IW:0]   w_rp_m1;
  logic [7:0]    w_rd_byte;

  nmea_hex2nib u_hex2nib (
    .i_char   (rx_data),
    .o_nib    (w_nib),
    .o_is_hex (w_is_hex)
  );

  // Payload store; a byte arriving at a full buffer is the overflow case
  assign w_buf_we = (r_state == ST_COLLECT) && rx_valid && (rx_data != STAR) &&
                    (rx_data != DOLLAR) && (r_idx != (IW+1)'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx[IW-1:0]] <= rx_data;
  end

  // Length guard keeps stale buffer contents from matching a short sentence
  assign w_hdr_ok = (r_idx >= (IW+1)'(6)) &&
                    (r_buf[0] == HDR_G) && (r_buf[1] == HDR_P) &&
                    (r_buf[2] == HDR_R) && (r_buf[3] == HDR_M) &&
                    (r_buf[4] == HDR_C) && (r_buf[5] == COMMA);

  // Replay position 0 is the synthesised '$'; position k is r_buf[k-1]
  assign w_rp_m1   = r_rp - 1'b1;
  assign w_rd_byte = r_buf[w_rp_m1[IW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_HUNT;
      r_idx      <= '0;
      r_rp       <= '0;
      r_xor      <= '0;
      r_ck       <= '0;
      r_gap      <= '0;
      r_tmo      <= '0;
      r_fl_cnt   <= '0;
      r_p_char   <= '0;
      r_p_valid  <= 1'b0;
      r_p_rst_n  <= 1'b1;
      r_ok_cnt   <= '0;
      r_err_cnt  <= '0;
      r_fix_lost <= 1'b0;
    end else begin
      r_p_valid <= 1'b0;
      r_p_rst_n <= 1'b1;

      // Fix-loss supervision runs in every state, counter saturates
      if (p_done) begin
        r_fl_cnt   <= '0;
        r_fix_lost <= 1'b0;
      end else if (r_fl_cnt != FW'(FIX_LOSS_CYC)) begin
        r_fl_cnt <= r_fl_cnt + 1'b1;
        if (r_fl_cnt == FW'(FIX_LOSS_CYC - 1)) r_fix_lost <= 1'b1;
      end

      case (r_state)
        ST_HUNT: begin
          if (rx_valid && rx_data == DOLLAR) begin
            r_idx   <= '0;
            r_xor   <= '0;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (rx_valid) begin
            if (rx_data == STAR) begin
              r_state <= ST_CK_HI;
            end else if (rx_data == DOLLAR) begin
              r_idx <= '0;
              r_xor <= '0;
            end else if (r_idx == (IW+1)'(BUF_DEPTH)) begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= ST_HUNT;
            end else begin
              r_xor <= r_xor ^ rx_data;
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_CK_HI: begin
          if (rx_valid) begin
            if (w_is_hex) begin
              r_ck[7:4] <= w_nib;
              r_state   <= ST_CK_LO;
            end else begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= ST_HUNT;
            end
          end
        end
        ST_CK_LO: begin
          if (rx_valid) begin
            if (w_is_hex) begin
              r_ck[3:0] <= w_nib;
              r_state   <= ST_CHECK;
            end else begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= ST_HUNT;
            end
          end
        end
        ST_CHECK: begin
          if (r_ck != r_xor) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= ST_HUNT;
          end else if (w_hdr_ok) begin
            r_rp    <= '0;
            r_gap   <= '0;
            r_state <= ST_REPLAY;
          end else begin
            r_state <= ST_HUNT;
          end
        end
        ST_REPLAY: begin
          // r_gap counts the idle cycles still owed after the last emitted byte
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (r_rp == r_idx + 1'b1) begin
            r_tmo   <= '0;
            r_state <= ST_WAIT_DONE;
          end else begin
            r_p_valid <= 1'b1;
            r_p_char  <= (r_rp == '0) ? DOLLAR : w_rd_byte;
            r_rp      <= r_rp + 1'b1;
            r_gap     <= GW'(GAP);
          end
        end
        ST_WAIT_DONE: begin
          if (p_done) begin
            r_ok_cnt <= sat_inc(r_ok_cnt);
            r_state  <= ST_HUNT;
          end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            // Registered so the parser reset is low for exactly the ABORT cycle
            r_p_rst_n <= 1'b0;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= ST_ABORT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_ABORT: r_state <= ST_HUNT;
        default:  r_state <= ST_HUNT;
      endcase
    end
  end

  assign p_char   = r_p_char;
  assign p_valid  = r_p_valid;
  assign p_rst_n  = r_p_rst_n;
  assign busy     = (r_state != ST_HUNT);
  assign ok_cnt   = r_ok_cnt;
  assign err_cnt  = r_err_cnt;
  assign fix_lost = r_fix_lost;

endmodule

// File: doc/nmea_replay_ctrl.md
Name: nmea_replay_ctrl

Overview:
- Controller between the UART receiver and the RMC time parser.
- Captures one NMEA sentence into a local buffer and checks its XOR checksum.
- Only checksum-valid GPRMC sentences are replayed byte-by-byte to the parser, paced to suit the parser's header timing. The block then waits for parser completion, resets a hung parser on timeout, and raises a fix-loss flag.

Parameters:
- BUF_DEPTH, 128, payload bytes stored between '$' and '*'.
- GAP, 2, idle cycles with p_valid low between replayed bytes (minimum 2).
- TIMEOUT_CYC, 1024, cycles allowed in WAIT_DONE before the parser is aborted.
- FIX_LOSS_CYC, 100000000, cycles without p_done before fix_lost asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- p_char  out  8  byte to parser
- p_valid  out  1  one-cycle strobe, p_char valid
- p_done  in  1  parser completion (NSR)
- p_rst_n  out  1  parser reset, low for exactly one cycle on abort
- busy  out  1  high in any state except HUNT
- ok_cnt  out  8  sentences that completed with p_done, saturating at 255
- err_cnt  out  8  checksum/hex/overflow errors, saturating at 255
- fix_lost  out  1  no p_done for FIX_LOSS_CYC cycles

Behaviour:
- Reset values: p_char=0, p_valid=0, p_rst_n=1, busy=0, ok_cnt=0, err_cnt=0, fix_lost=0, state=HUNT, all counters 0.
- FSM states: HUNT, COLLECT, CK_HI, CK_LO, CHECK, REPLAY, WAIT_DONE, ABORT.
- HUNT: on rx_valid with '$' (0x24), clear idx and xor, then go to COLLECT.
- COLLECT, rx_valid with '*': store nothing, go to CK_HI.
- COLLECT, rx_valid with '$': restart the sentence (idx=0, xor=0). This is not counted as an error.
- COLLECT, rx_valid with any other byte: buf[idx]<=byte, xor^=byte, idx++.
- COLLECT overflow: a byte arriving with idx==BUF_DEPTH gives err_cnt+1 and a return to HUNT.
- CK_HI / CK_LO: each state takes one rx_valid byte. Accepted digits are '0'-'9', 'A'-'F' and 'a'-'f'. Any non-hex byte gives err_cnt+1 and a return to HUNT.
- CHECK (one cycle):
  - rx_ck != xor: err_cnt+1, go to HUNT.
  - Checksum matches and buf[0..5] == "GPRMC,": go to REPLAY.
  - Checksum matches, other sentence type: go to HUNT silently.
- REPLAY: emits '$' first, then buf[0..idx-1].
  - Each byte gets one cycle with p_valid=1, followed by GAP cycles with p_valid=0.
  - After the last byte's gap, go to WAIT_DONE.
  - The '*' and checksum digits are never replayed.
- WAIT_DONE:
  - p_done=1: ok_cnt+1 (saturating), reset the fix-loss counter, clear fix_lost, go to HUNT.
  - Timeout counter reaches TIMEOUT_CYC-1 without p_done: go to ABORT.
- ABORT (one cycle): p_rst_n=0, err_cnt+1, then go to HUNT.
- rx_valid bytes arriving in CHECK, REPLAY, WAIT_DONE or ABORT are dropped. Replay time is far shorter than one UART byte time.
- Fix-loss counter:
  - Free-running and saturating.
  - fix_lost=1 once the count reaches FIX_LOSS_CYC.
  - Clears only on p_done.
- p_done arriving outside WAIT_DONE is ignored except for fix-loss handling (counter reset, fix_lost cleared).
- Reset asserted mid-operation: immediate return to reset values. Buffer contents need not be cleared.

Decomposition:
- Package nmea_pkg holds:
  - state encoding;
  - ASCII constants (DOLLAR 0x24, STAR 0x2A, COMMA 0x2C);
  - the "GPRMC," header byte constants.
- One sub-module: nmea_hex2nib, combinational. Maps an ASCII byte to a 4-bit nibble plus an is_hex flag; used by CK_HI and CK_LO.

Test Plan:
- Checksum pass: "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n" -> replay starts with '$','G','P'; consecutive p_valid pulses are exactly GAP+1 cycles apart; with the real parser attached, hr=12, min=35, sec=19; ok_cnt=1.
- Same sentence with checksum "*6B" -> no p_valid pulse, err_cnt=1, busy low within 1 cycle of the last digit.
- Lowercase "*6a" -> accepted, identical to the pass case. "*6G" -> err_cnt+1, no replay.
- "$GPGGA,...*" with a correct checksum -> no replay, no counter change. A 130-byte body with no '*' -> err_cnt=1 (overflow).
- Parser stub that never asserts p_done -> p_rst_n low for exactly 1 cycle TIMEOUT_CYC cycles after entering WAIT_DONE; err_cnt+1; back in HUNT.
- With FIX_LOSS_CYC=50: no p_done for 50 cycles -> fix_lost=1; next valid sentence completes -> fix_lost=0. Reset asserted during REPLAY -> p_valid=0 and busy=0 immediately, counters 0.
